// File: rtl/register_rename_table_ckpt_pkg.sv
// rtl/register_rename_table_ckpt_pkg.sv - shared register and map types for the rename table
package register_rename_table_ckpt_pkg;

    localparam int MIPS_REG_COUNT = 32;
    localparam int MIPS_W         = 5;
    localparam int PHYS_W         = 7;

    typedef logic [MIPS_W-1:0] MipsReg;
    typedef logic [PHYS_W-1:0] PhysReg;
    typedef PhysReg RenameMap [MIPS_REG_COUNT];

endpackage

// File: rtl/register_rename_table_ckpt_rename_group_bypass.sv
// rtl/register_rename_table_ckpt_rename_group_bypass.sv - intra-group source/old-phys lookup with bypass
// Honours RENAME_TABLE_ZERO_PIN_EN (register 0 reads phys 0, never bypassed).
module rename_group_bypass
    import register_rename_table_ckpt_pkg::*;
#(
    parameter int RENAME_WIDTH = 2
) (
    input  RenameMap                 map,
    input  logic [RENAME_WIDTH-1:0]  ren_valid,
    input  MipsReg                   ren_dst      [RENAME_WIDTH],
    input  PhysReg                   ren_new_phys [RENAME_WIDTH],
    input  MipsReg                   src_mips     [RENAME_WIDTH][2],
    output PhysReg                   src_phys     [RENAME_WIDTH][2],
    output PhysReg                   ren_old_phys [RENAME_WIDTH]
);

    // Older slots are scanned in ascending order so the youngest older writer wins.
    always_comb begin
        for (int j = 0; j < RENAME_WIDTH; j++) begin
            for (int k = 0; k < 2; k++) begin
                src_phys[j][k] = map[src_mips[j][k]];
                for (int i = 0; i < RENAME_WIDTH; i++) begin
                    if (i < j && ren_valid[i] && ren_dst[i] == src_mips[j][k])
                        src_phys[j][k] = ren_new_phys[i];
                end
`ifdef RENAME_TABLE_ZERO_PIN_EN
                if (src_mips[j][k] == '0)
                    src_phys[j][k] = '0;
`endif
            end
            ren_old_phys[j] = map[ren_dst[j]];
            for (int i = 0; i < RENAME_WIDTH; i++) begin
                if (i < j && ren_valid[i] && ren_dst[i] == ren_dst[j])
                    ren_old_phys[j] = ren_new_phys[i];
            end
`ifdef RENAME_TABLE_ZERO_PIN_EN
            if (ren_dst[j] == '0)
                ren_old_phys[j] = '0;
`endif
        end
    end

endmodule

// File: rtl/register_rename_table_ckpt.sv
// rtl/register_rename_table_ckpt.sv - multi-port speculative rename map with branch checkpoints
// Optional RENAME_TABLE_ZERO_PIN_EN pins MIPS register 0 to physical register 0.
module register_rename_table_ckpt
    import register_rename_table_ckpt_pkg::*;
#(
    parameter int RENAME_WIDTH = 2,
    parameter int COMMIT_WIDTH = 2,
    parameter int NUM_CKPT     = 4,
    parameter int CKPT_IDX_W   = $clog2(NUM_CKPT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic [RENAME_WIDTH-1:0]  i_ren_valid,
    input  MipsReg                   i_ren_dst      [RENAME_WIDTH],
    input  PhysReg                   i_ren_new_phys [RENAME_WIDTH],
    output PhysReg                   o_ren_old_phys [RENAME_WIDTH],
    input  MipsReg                   i_src_mips     [RENAME_WIDTH][2],
    output PhysReg                   o_src_phys     [RENAME_WIDTH][2],
    input  logic                     i_ckpt_take,
    output logic [CKPT_IDX_W-1:0]    o_ckpt_id,
    output logic                     o_ckpt_full,
    input  logic                     i_ckpt_release,
    input  logic                     i_ckpt_restore,
    input  logic [CKPT_IDX_W-1:0]    i_ckpt_restore_id,
    input  logic [COMMIT_WIDTH-1:0]  i_commit_valid,
    input  MipsReg                   i_commit_mips  [COMMIT_WIDTH],
    input  PhysReg                   i_commit_phys  [COMMIT_WIDTH]
);

    RenameMap                spec_map;
    RenameMap                commit_map;
    RenameMap                post_map;
    RenameMap                commit_next;
    RenameMap                ckpt [NUM_CKPT];
    logic [CKPT_IDX_W-1:0]   head;
    logic [CKPT_IDX_W-1:0]   tail;
    logic [CKPT_IDX_W:0]     count;
    logic [CKPT_IDX_W-1:0]   head_next;
    logic [CKPT_IDX_W-1:0]   restore_count;
    logic                    release_ok;
    logic                    take_ok;

    rename_group_bypass #(.RENAME_WIDTH(RENAME_WIDTH)) u_bypass (
        .map          (spec_map),
        .ren_valid    (i_ren_valid),
        .ren_dst      (i_ren_dst),
        .ren_new_phys (i_ren_new_phys),
        .src_mips     (i_src_mips),
        .src_phys     (o_src_phys),
        .ren_old_phys (o_ren_old_phys)
    );

    always_comb begin
        post_map = spec_map;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
`ifdef RENAME_TABLE_ZERO_PIN_EN
            if (i_ren_valid[i] && i_ren_dst[i] != '0)
`else
            if (i_ren_valid[i])
`endif
                post_map[i_ren_dst[i]] = i_ren_new_phys[i];
        end
        commit_next = commit_map;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
`ifdef RENAME_TABLE_ZERO_PIN_EN
            if (i_commit_valid[i] && i_commit_mips[i] != '0)
`else
            if (i_commit_valid[i])
`endif
                commit_next[i_commit_mips[i]] = i_commit_phys[i];
        end
    end

    assign o_ckpt_full   = (count == (CKPT_IDX_W+1)'(NUM_CKPT));
    assign o_ckpt_id     = tail;
    assign release_ok    = i_ckpt_release && (count != '0);
    assign head_next     = head + CKPT_IDX_W'(release_ok);
    assign restore_count = i_ckpt_restore_id - head_next;
    // A same-cycle release frees the head slot, so a take can reuse it even when full.
    assign take_ok       = i_ckpt_take && (!o_ckpt_full || release_ok) && !i_flush && !i_ckpt_restore;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MIPS_REG_COUNT; i++) begin
                spec_map[i]   <= PhysReg'(i);
                commit_map[i] <= PhysReg'(i);
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            commit_map <= commit_next;
            if (i_flush) begin
                spec_map <= commit_next;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
            end else if (i_ckpt_restore) begin
                for (int i = 0; i < MIPS_REG_COUNT; i++) begin
`ifdef RENAME_TABLE_ZERO_PIN_EN
                    if (i != 0)
`endif
                        spec_map[i] <= ckpt[i_ckpt_restore_id][i];
                end
                head  <= head_next;
                tail  <= i_ckpt_restore_id;
                count <= {1'b0, restore_count};
            end else begin
                spec_map <= post_map;
                head     <= head_next;
                if (take_ok)
                    tail <= tail + 1'b1;
                count <= count + (CKPT_IDX_W+1)'(take_ok) - (CKPT_IDX_W+1)'(release_ok);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (take_ok)
            ckpt[tail] <= post_map;
    end

endmodule

// File: tb/tb_register_rename_table_ckpt.sv
// tb/tb_register_rename_table_ckpt.sv - directed and random checks of the checkpointed rename table
module tb_register_rename_table_ckpt;
    import register_rename_table_ckpt_pkg::*;

    localparam int RW = 2;
    localparam int CW = 2;
    localparam int NC = 4;
    localparam int IW = 2;

    logic           clk;
    logic           rst_n;
    logic           flush;
    logic [RW-1:0]  ren_valid;
    MipsReg         ren_dst      [RW];
    PhysReg         ren_new_phys [RW];
    PhysReg         ren_old_phys [RW];
    MipsReg         src_mips     [RW][2];
    PhysReg         src_phys     [RW][2];
    logic           ckpt_take;
    logic [IW-1:0]  ckpt_id;
    logic           ckpt_full;
    logic           ckpt_release;
    logic           ckpt_restore;
    logic [IW-1:0]  ckpt_restore_id;
    logic [CW-1:0]  commit_valid;
    MipsReg         commit_mips  [CW];
    PhysReg         commit_phys  [CW];

    int n_assert = 0;
    int n_fail   = 0;

    int m_spec   [MIPS_REG_COUNT];
    int m_commit [MIPS_REG_COUNT];
    int m_snap   [NC][MIPS_REG_COUNT];
    int m_live   [$];
    int m_tail;

    register_rename_table_ckpt #(.RENAME_WIDTH(RW), .COMMIT_WIDTH(CW), .NUM_CKPT(NC)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_flush           (flush),
        .i_ren_valid       (ren_valid),
        .i_ren_dst         (ren_dst),
        .i_ren_new_phys    (ren_new_phys),
        .o_ren_old_phys    (ren_old_phys),
        .i_src_mips        (src_mips),
        .o_src_phys        (src_phys),
        .i_ckpt_take       (ckpt_take),
        .o_ckpt_id         (ckpt_id),
        .o_ckpt_full       (ckpt_full),
        .i_ckpt_release    (ckpt_release),
        .i_ckpt_restore    (ckpt_restore),
        .i_ckpt_restore_id (ckpt_restore_id),
        .i_commit_valid    (commit_valid),
        .i_commit_mips     (commit_mips),
        .i_commit_phys     (commit_phys)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        flush = 0; ren_valid = '0; ckpt_take = 0; ckpt_release = 0;
        ckpt_restore = 0; ckpt_restore_id = '0; commit_valid = '0;
        for (int i = 0; i < RW; i++) begin
            ren_dst[i] = '0; ren_new_phys[i] = '0;
            src_mips[i][0] = '0; src_mips[i][1] = '0;
        end
        for (int i = 0; i < CW; i++) begin
            commit_mips[i] = '0; commit_phys[i] = '0;
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < MIPS_REG_COUNT; r++) begin
            m_spec[r] = r; m_commit[r] = r;
        end
        m_live.delete();
        m_tail = 0;
    endtask

    function automatic int m_lookup(int j, int r);
        int p = m_spec[r];
        for (int i = 0; i < j; i++)
            if (ren_valid[i] && int'(ren_dst[i]) == r) p = int'(ren_new_phys[i]);
`ifdef RENAME_TABLE_ZERO_PIN_EN
        if (r == 0) p = 0;
`endif
        return p;
    endfunction

    task automatic model_update();
        int post [MIPS_REG_COUNT];
        int cn   [MIPS_REG_COUNT];
        int pos;
        bit rel;
        bit tk;
        post = m_spec;
        cn   = m_commit;
        for (int i = 0; i < RW; i++)
            if (ren_valid[i]) post[ren_dst[i]] = int'(ren_new_phys[i]);
        for (int i = 0; i < CW; i++)
            if (commit_valid[i]) cn[commit_mips[i]] = int'(commit_phys[i]);
`ifdef RENAME_TABLE_ZERO_PIN_EN
        post[0] = 0; cn[0] = 0;
`endif
        if (flush) begin
            m_spec = cn;
            m_live.delete();
            m_tail = 0;
        end else if (ckpt_restore) begin
            pos = m_live.size();
            for (int p = 0; p < m_live.size(); p++)
                if (m_live[p] == int'(ckpt_restore_id)) pos = p;
            m_spec = m_snap[ckpt_restore_id];
            while (m_live.size() > pos) void'(m_live.pop_back());
            if (ckpt_release && m_live.size() > 0) void'(m_live.pop_front());
            m_tail = int'(ckpt_restore_id);
        end else begin
            rel = ckpt_release && m_live.size() > 0;
            tk  = ckpt_take && (m_live.size() < NC || rel);
            m_spec = post;
            if (rel) void'(m_live.pop_front());
            if (tk) begin
                m_snap[m_tail] = post;
                m_live.push_back(m_tail);
                m_tail = (m_tail + 1) % NC;
            end
        end
        m_commit = cn;
    endtask

    // Called at a negedge with inputs applied; checks outputs, then advances one clock.
    task automatic cycle();
        #1;
        for (int j = 0; j < RW; j++) begin
            for (int k = 0; k < 2; k++)
                chk($sformatf("src_phys[%0d][%0d]", j, k), 32'(src_phys[j][k]), 32'(m_lookup(j, int'(src_mips[j][k]))));
            chk($sformatf("ren_old_phys[%0d]", j), 32'(ren_old_phys[j]), 32'(m_lookup(j, int'(ren_dst[j]))));
        end
        chk("ckpt_full", 32'(ckpt_full), 32'(m_live.size() == NC));
        chk("ckpt_id", 32'(ckpt_id), 32'(m_tail));
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        int idx;
        idle();
        rst_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;

        // Reset state
        src_mips[0][0] = 5; src_mips[0][1] = 31;
        #1;
        chk("reset_src5", 32'(src_phys[0][0]), 5);
        chk("reset_src31", 32'(src_phys[0][1]), 31);
        chk("reset_full", 32'(ckpt_full), 0);
        chk("reset_id", 32'(ckpt_id), 0);
        cycle();

        // Intra-group bypass on a shared destination
        idle();
        ren_valid = 2'b11;
        ren_dst[0] = 3; ren_new_phys[0] = 40;
        ren_dst[1] = 3; ren_new_phys[1] = 41; src_mips[1][0] = 3;
        #1;
        chk("byp_src1", 32'(src_phys[1][0]), 40);
        chk("byp_old1", 32'(ren_old_phys[1]), 40);
        chk("byp_old0", 32'(ren_old_phys[0]), 3);
        cycle();
        idle();
        src_mips[0][0] = 3;
        #1;
        chk("r3_after", 32'(src_phys[0][0]), 41);
        cycle();

        // Fill checkpoints, ignored take when full, release+take when full
        idle();
        ckpt_take = 1;
        repeat (4) cycle();
        chk("full_after4", 32'(ckpt_full), 1);
        cycle();
        chk("fifth_take_id", 32'(ckpt_id), 0);
        chk("fifth_take_full", 32'(ckpt_full), 1);
        ckpt_release = 1;
        cycle();
        chk("reltake_id", 32'(ckpt_id), 1);
        chk("reltake_full", 32'(ckpt_full), 1);

        // Restore after a younger remap
        idle(); flush = 1; cycle();
        idle(); ckpt_take = 1; cycle();
        idle(); ren_valid = 2'b01; ren_dst[0] = 7; ren_new_phys[0] = 50; ckpt_take = 1;
        #1;
        chk("take_id1", 32'(ckpt_id), 1);
        cycle();
        idle(); ren_valid = 2'b01; ren_dst[0] = 7; ren_new_phys[0] = 60; cycle();
        idle(); ckpt_restore = 1; ckpt_restore_id = 1; cycle();
        idle(); src_mips[0][0] = 7;
        #1;
        chk("restore_r7", 32'(src_phys[0][0]), 50);
        chk("restore_tail", 32'(ckpt_id), 1);
        chk("restore_notfull", 32'(ckpt_full), 0);
        cycle();
        idle(); ckpt_take = 1;
        repeat (3) cycle();
        chk("restore_count1", 32'(ckpt_full), 1);

        // Commit on both ports plus flush
        idle(); flush = 1; commit_valid = 2'b11;
        commit_mips[0] = 9; commit_phys[0] = 20;
        commit_mips[1] = 9; commit_phys[1] = 70;
        cycle();
        idle(); src_mips[0][0] = 9; src_mips[0][1] = 7;
        #1;
        chk("flush_r9", 32'(src_phys[0][0]), 70);
        chk("flush_r7", 32'(src_phys[0][1]), 7);
        chk("flush_full", 32'(ckpt_full), 0);
        chk("flush_id", 32'(ckpt_id), 0);
        cycle();

        // Register 0 rename and commit
        idle(); ren_valid = 2'b01; ren_dst[0] = 0; ren_new_phys[0] = 33;
        commit_valid = 2'b01; commit_mips[0] = 0; commit_phys[0] = 33;
        cycle();
        idle(); flush = 1; src_mips[0][0] = 0;
        #1;
`ifdef RENAME_TABLE_ZERO_PIN_EN
        chk("r0_spec", 32'(src_phys[0][0]), 0);
`else
        chk("r0_spec", 32'(src_phys[0][0]), 33);
`endif
        cycle();
        idle(); src_mips[0][0] = 0;
        #1;
`ifdef RENAME_TABLE_ZERO_PIN_EN
        chk("r0_commit", 32'(src_phys[0][0]), 0);
`else
        chk("r0_commit", 32'(src_phys[0][0]), 33);
`endif
        cycle();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            idle();
            for (int i = 0; i < RW; i++) begin
                ren_valid[i]    = ($urandom_range(0, 99) < 60);
                ren_dst[i]      = MipsReg'($urandom_range(0, 31));
                ren_new_phys[i] = PhysReg'($urandom_range(0, 127));
                src_mips[i][0]  = MipsReg'($urandom_range(0, 31));
                src_mips[i][1]  = (i > 0 && $urandom_range(0, 1) == 1) ? ren_dst[0] : MipsReg'($urandom_range(0, 31));
            end
            for (int i = 0; i < CW; i++) begin
                commit_valid[i] = ($urandom_range(0, 99) < 50);
                commit_mips[i]  = MipsReg'($urandom_range(0, 31));
                commit_phys[i]  = PhysReg'($urandom_range(0, 127));
            end
            ckpt_take    = ($urandom_range(0, 99) < 35);
            ckpt_release = ($urandom_range(0, 99) < 25);
            ckpt_restore_id = IW'($urandom_range(0, NC - 1));
            if (m_live.size() > 0 && $urandom_range(0, 99) < 10) begin
                idx = int'($urandom_range(0, m_live.size() - 1));
                ckpt_restore = 1;
                ckpt_restore_id = IW'(m_live[idx]);
                if (idx == 0) ckpt_release = 0;
            end
            flush = ($urandom_range(0, 99) < 3);
            cycle();
        end

        // Reset asserted mid-operation
        idle();
        ren_valid = 2'b01; ren_dst[0] = 12; ren_new_phys[0] = 99; ckpt_take = 1;
        cycle();
        idle(); ckpt_take = 1; cycle();
        idle();
        src_mips[0][0] = 12;
        rst_n = 0;
        #1;
        chk("midrst_r12", 32'(src_phys[0][0]), 12);
        chk("midrst_full", 32'(ckpt_full), 0);
        chk("midrst_id", 32'(ckpt_id), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
